one_wire_bram_arbiter: RTL and testbench

//  Shares the single-port one_wire_bram between two requesters: the UART-side data controller (writes) and the 1-wire interface (reads).
//  One-deep request buffer per side, round-robin grant, read-after-write ordering on same address.

---
 rtl/one_wire_pkg.sv | 23 ++
 rtl/one_wire_bram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_one_wire_bram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/one_wire_pkg.sv
// Shared definitions for the one-wire BRAM arbiter.
//   state_t / IDLE..RD_WAIT : arbiter FSM state encodings
//   gnt_t / GNT_WR, GNT_RD  : last-grant side encodings for round-robin
//   RD_LAT_MAX              : largest supported BRAM read latency
//   CNT_W                   : width of the read-latency countdown
package one_wire_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t WR_ISSUE = 2'd1;
  localparam state_t RD_ISSUE = 2'd2;
  localparam state_t RD_WAIT  = 2'd3;

  typedef logic gnt_t;

  localparam gnt_t GNT_WR = 1'b0;
  localparam gnt_t GNT_RD = 1'b1;

  localparam int unsigned RD_LAT_MAX = 3;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/one_wire_bram_arbiter.sv
// Shares the single-port one_wire_bram between the UART-side write requester
// and the 1-wire read requester. One-deep buffer per side, round-robin grant,
// and a write to the same address as a pending read is always issued first.
// Ports:
//   clk, reset                       clock, async active-low reset
//   wr_req/wr_addr/wr_data/wr_ready  write request side (accept on req&ready)
//   rd_req/rd_addr/rd_ready          read request side (accept on req&ready)
//   rd_data/rd_dv                    read result, rd_dv pulses one cycle
//   bram_we/bram_re/bram_addr/
//   bram_wdata/bram_rdata            BRAM control and data pins
// All outputs are registered. RD_LAT must lie in 1..RD_LAT_MAX.
module one_wire_bram_arbiter
  import one_wire_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_dv,
  output logic              bram_we,
  output logic              bram_re,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  state_t             state_q, state_d;
  logic               wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  gnt_t               last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]   rd_wait_cnt_q, rd_wait_cnt_d;

  logic               wr_ready_d, rd_ready_d, rd_dv_d;
  logic               bram_we_d, bram_re_d;
  logic [DATA_W-1:0]  rd_data_d, bram_wdata_d;
  logic [ADDR_W-1:0]  bram_addr_d;

  logic               grant_wr, grant_rd;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, including the grant decision taken in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_pend_q && rd_pend_q) begin
          // Same address: write goes first so the read sees the new data.
          if (rd_addr_q == wr_addr_q)     state_d = WR_ISSUE;
          else if (last_gnt_q == GNT_RD)  state_d = WR_ISSUE;
          else                            state_d = RD_ISSUE;
        end else if (wr_pend_q) begin
          state_d = WR_ISSUE;
        end else if (rd_pend_q) begin
          state_d = RD_ISSUE;
        end
      end
      WR_ISSUE: state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (rd_wait_cnt_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign grant_wr = (state_q == IDLE) && (state_d == WR_ISSUE);
  assign grant_rd = (state_q == IDLE) && (state_d == RD_ISSUE);

  // Next values of buffers, counter and registered outputs
  always_comb begin
    wr_pend_d     = wr_pend_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_pend_d     = rd_pend_q;
    rd_addr_d     = rd_addr_q;
    last_gnt_d    = last_gnt_q;
    rd_wait_cnt_d = rd_wait_cnt_q;
    bram_we_d     = 1'b0;
    bram_re_d     = 1'b0;
    bram_addr_d   = bram_addr;
    bram_wdata_d  = bram_wdata;
    rd_dv_d       = 1'b0;
    rd_data_d     = rd_data;

    // Grants free the buffer on the same edge the strobe is registered.
    if (grant_wr) begin
      bram_we_d    = 1'b1;
      bram_addr_d  = wr_addr_q;
      bram_wdata_d = wr_data_q;
      wr_pend_d    = 1'b0;
      last_gnt_d   = GNT_WR;
    end
    if (grant_rd) begin
      bram_re_d     = 1'b1;
      bram_addr_d   = rd_addr_q;
      rd_pend_d     = 1'b0;
      last_gnt_d    = GNT_RD;
      rd_wait_cnt_d = CNT_W'(RD_LAT);
    end

    // Countdown spans RD_ISSUE and RD_WAIT so capture lands RD_LAT+1 after bram_re.
    if (state_q == RD_ISSUE) begin
      rd_wait_cnt_d = rd_wait_cnt_q - CNT_W'(1);
    end else if (state_q == RD_WAIT) begin
      if (rd_wait_cnt_q == '0) begin
        rd_dv_d   = 1'b1;
        rd_data_d = bram_rdata;
      end else begin
        rd_wait_cnt_d = rd_wait_cnt_q - CNT_W'(1);
      end
    end

    // A ready side is never pending, so accepts cannot collide with grants.
    if (wr_req && wr_ready) begin
      wr_pend_d = 1'b1;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
    end
    if (rd_req && rd_ready) begin
      rd_pend_d = 1'b1;
      rd_addr_d = rd_addr;
    end

    wr_ready_d = ~wr_pend_d;
    rd_ready_d = ~rd_pend_d & (state_d != RD_WAIT);
  end

  // Buffers, counter and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      last_gnt_q    <= GNT_RD;
      rd_wait_cnt_q <= '0;
      wr_ready      <= 1'b1;
      rd_ready      <= 1'b1;
      rd_dv         <= 1'b0;
      rd_data       <= '0;
      bram_we       <= 1'b0;
      bram_re       <= 1'b0;
      bram_addr     <= '0;
      bram_wdata    <= '0;
    end else begin
      wr_pend_q     <= wr_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_pend_q     <= rd_pend_d;
      rd_addr_q     <= rd_addr_d;
      last_gnt_q    <= last_gnt_d;
      rd_wait_cnt_q <= rd_wait_cnt_d;
      wr_ready      <= wr_ready_d;
      rd_ready      <= rd_ready_d;
      rd_dv         <= rd_dv_d;
      rd_data       <= rd_data_d;
      bram_we       <= bram_we_d;
      bram_re       <= bram_re_d;
      bram_addr     <= bram_addr_d;
      bram_wdata    <= bram_wdata_d;
    end
  end

endmodule

// File: tb/tb_one_wire_bram_arbiter.sv
// Bench for one_wire_bram_arbiter: three instances with RD_LAT 1, 2, 3, each
// attached to its own behavioural BRAM. Directed cases run on the RD_LAT=1
// instance; a randomized request stream runs on every instance and is checked
// against request queues and a reference memory image.
module tb_one_wire_bram_arbiter;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NI     = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] d;
  } dv_t;

  logic clk;
  logic reset;

  logic              wr_req     [NI];
  logic [ADDR_W-1:0] wr_addr    [NI];
  logic [DATA_W-1:0] wr_data    [NI];
  logic              wr_ready   [NI];
  logic              rd_req     [NI];
  logic [ADDR_W-1:0] rd_addr    [NI];
  logic              rd_ready   [NI];
  logic [DATA_W-1:0] rd_data    [NI];
  logic              rd_dv      [NI];
  logic              bram_we    [NI];
  logic              bram_re    [NI];
  logic [ADDR_W-1:0] bram_addr  [NI];
  logic [DATA_W-1:0] bram_wdata [NI];
  logic [DATA_W-1:0] bram_rdata [NI];

  logic [DATA_W-1:0] ref_mem [NI][DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] pipe [3];

    one_wire_bram_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .RD_LAT(g + 1)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_req     (wr_req[g]),
      .wr_addr    (wr_addr[g]),
      .wr_data    (wr_data[g]),
      .wr_ready   (wr_ready[g]),
      .rd_req     (rd_req[g]),
      .rd_addr    (rd_addr[g]),
      .rd_ready   (rd_ready[g]),
      .rd_data    (rd_data[g]),
      .rd_dv      (rd_dv[g]),
      .bram_we    (bram_we[g]),
      .bram_re    (bram_re[g]),
      .bram_addr  (bram_addr[g]),
      .bram_wdata (bram_wdata[g]),
      .bram_rdata (bram_rdata[g])
    );

    initial begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end

    // Behavioural BRAM: read data appears g+1 cycles after the bram_re cycle;
    // 0xEE marks "no read" so a mistimed capture is visible.
    always @(posedge clk) begin
      if (bram_we[g]) mem[bram_addr[g]] <= bram_wdata[g];
      pipe[0] <= bram_re[g] ? mem[bram_addr[g]] : DATA_W'(8'hEE);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    assign bram_rdata[g] = pipe[g];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom);
    return ADDR_W'($urandom_range(0, 7));
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Present requests on instance 0 for one edge; returns at the following negedge.
  task automatic req0(input bit w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input bit r, input logic [ADDR_W-1:0] ra);
    @(negedge clk);
    wr_req[0] = w; wr_addr[0] = wa; wr_data[0] = wd;
    rd_req[0] = r; rd_addr[0] = ra;
    if (w) ref_mem[0][wa] = wd;
    @(negedge clk);
    wr_req[0] = 1'b0;
    rd_req[0] = 1'b0;
  endtask

  // Called at a negedge; waits (bounded) for rd_dv on instance k.
  task automatic wait_rd_dv(input int k, output logic [DATA_W-1:0] d);
    int n = 0;
    while (!rd_dv[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_dv_seen", 32'(rd_dv[k]), 32'd1);
    d = rd_data[k];
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_ready"},   32'(wr_ready[0]),   32'd1);
    check({tag, "_rd_ready"},   32'(rd_ready[0]),   32'd1);
    check({tag, "_rd_dv"},      32'(rd_dv[0]),      32'd0);
    check({tag, "_rd_data"},    32'(rd_data[0]),    32'd0);
    check({tag, "_bram_we"},    32'(bram_we[0]),    32'd0);
    check({tag, "_bram_re"},    32'(bram_re[0]),    32'd0);
    check({tag, "_bram_addr"},  32'(bram_addr[0]),  32'd0);
    check({tag, "_bram_wdata"}, 32'(bram_wdata[0]), 32'd0);
  endtask

  // Random stream on instance k, checked against request queues and ref_mem.
  task automatic run_random(input int k, input int nreq);
    wr_t               wq[$];
    logic [ADDR_W-1:0] rq[$];
    dv_t               dvq[$];
    wr_t               w;
    dv_t               e;
    logic [ADDR_W-1:0] a;
    int                cyc    = 0;
    int                issued = 0;
    int                lat    = k + 1;

    while ((issued < nreq || wq.size() > 0 || rq.size() > 0 || dvq.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;

      if (bram_we[k] || bram_re[k])
        check("we_re_exclusive", 32'(bram_we[k] & bram_re[k]), 32'd0);

      if (bram_we[k]) begin
        if (wq.size() == 0) begin
          check("we_spurious", 32'd1, 32'd0);
        end else begin
          w = wq.pop_front();
          check("we_addr", 32'(bram_addr[k]), 32'(w.a));
          check("we_data", 32'(bram_wdata[k]), 32'(w.d));
          ref_mem[k][w.a] = w.d;
        end
      end

      if (bram_re[k]) begin
        if (rq.size() == 0) begin
          check("re_spurious", 32'd1, 32'd0);
        end else begin
          a = rq.pop_front();
          check("re_addr", 32'(bram_addr[k]), 32'(a));
          dvq.push_back('{due: cyc + lat + 1, d: ref_mem[k][a]});
        end
      end

      if (rd_dv[k]) begin
        if (dvq.size() == 0) begin
          check("rd_dv_spurious", 32'd1, 32'd0);
        end else begin
          e = dvq.pop_front();
          check("rd_dv_cycle", 32'(cyc), 32'(e.due));
          check("rd_data", 32'(rd_data[k]), 32'(e.d));
        end
      end
      if (dvq.size() > 0 && dvq[0].due < cyc) begin
        check("rd_dv_missing", 32'd0, 32'd1);
        void'(dvq.pop_front());
      end

      if (issued < nreq) begin
        wr_req[k]  = ($urandom_range(0, 1) == 1);
        wr_addr[k] = rand_addr();
        wr_data[k] = DATA_W'($urandom);
        rd_req[k]  = ($urandom_range(0, 1) == 1);
        rd_addr[k] = rand_addr();
        if (wr_req[k] && wr_ready[k]) begin
          wq.push_back('{a: wr_addr[k], d: wr_data[k]});
          issued++;
        end
        if (rd_req[k] && rd_ready[k]) begin
          rq.push_back(rd_addr[k]);
          issued++;
        end
      end else begin
        wr_req[k] = 1'b0;
        rd_req[k] = 1'b0;
      end
    end
    wr_req[k] = 1'b0;
    rd_req[k] = 1'b0;
    check("random_drained", 32'(cyc < 20000), 32'd1);
    check("random_wq_empty", 32'(wq.size()), 32'd0);
    check("random_rq_empty", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;

    reset = 1'b0;
    for (int k = 0; k < int'(NI); k++) begin
      wr_req[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
      rd_req[k] = 1'b0; rd_addr[k] = '0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[k][i] = '0;
    end
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;

    // Single write 0x15 <- 0xA5
    req0(1'b1, 7'h15, 8'hA5, 1'b0, '0);
    check("w1_ready_low", 32'(wr_ready[0]), 32'd0);
    check("w1_we_early", 32'(bram_we[0]), 32'd0);
    @(negedge clk);
    check("w1_we", 32'(bram_we[0]), 32'd1);
    check("w1_addr", 32'(bram_addr[0]), 32'h15);
    check("w1_wdata", 32'(bram_wdata[0]), 32'hA5);
    check("w1_re", 32'(bram_re[0]), 32'd0);
    check("w1_ready_back", 32'(wr_ready[0]), 32'd1);
    @(negedge clk);
    check("w1_we_one_cycle", 32'(bram_we[0]), 32'd0);
    check("w1_addr_hold", 32'(bram_addr[0]), 32'h15);

    // Read 0x15
    req0(1'b0, '0, '0, 1'b1, 7'h15);
    check("r1_ready_low", 32'(rd_ready[0]), 32'd0);
    @(negedge clk);
    check("r1_re", 32'(bram_re[0]), 32'd1);
    check("r1_addr", 32'(bram_addr[0]), 32'h15);
    check("r1_we", 32'(bram_we[0]), 32'd0);
    @(negedge clk);
    check("r1_re_one_cycle", 32'(bram_re[0]), 32'd0);
    check("r1_dv_early", 32'(rd_dv[0]), 32'd0);
    check("r1_ready_wait", 32'(rd_ready[0]), 32'd0);
    @(negedge clk);
    check("r1_dv", 32'(rd_dv[0]), 32'd1);
    check("r1_data", 32'(rd_data[0]), 32'hA5);
    check("r1_ready_back", 32'(rd_ready[0]), 32'd1);
    @(negedge clk);
    check("r1_dv_one_cycle", 32'(rd_dv[0]), 32'd0);
    check("r1_data_hold", 32'(rd_data[0]), 32'hA5);

    // Concurrent, different addresses, last grant was read -> write first
    req0(1'b1, 7'h10, 8'h5A, 1'b1, 7'h20);
    @(negedge clk);
    check("rr1_we", 32'(bram_we[0]), 32'd1);
    check("rr1_re", 32'(bram_re[0]), 32'd0);
    check("rr1_waddr", 32'(bram_addr[0]), 32'h10);
    @(negedge clk);
    @(negedge clk);
    check("rr1_re_after", 32'(bram_re[0]), 32'd1);
    check("rr1_raddr", 32'(bram_addr[0]), 32'h20);
    wait_rd_dv(0, d);
    check("rr1_rdata", 32'(d), 32'(ref_mem[0][7'h20]));

    // Make the last grant a write, then concurrent -> read first
    req0(1'b1, 7'h30, 8'h11, 1'b0, '0);
    repeat (2) @(negedge clk);
    req0(1'b1, 7'h11, 8'h22, 1'b1, 7'h10);
    @(negedge clk);
    check("rr2_re", 32'(bram_re[0]), 32'd1);
    check("rr2_we", 32'(bram_we[0]), 32'd0);
    check("rr2_raddr", 32'(bram_addr[0]), 32'h10);
    @(negedge clk);
    check("rr2_we_held", 32'(bram_we[0]), 32'd0);
    @(negedge clk);
    check("rr2_dv", 32'(rd_dv[0]), 32'd1);
    check("rr2_rdata", 32'(rd_data[0]), 32'h5A);
    check("rr2_we_not_yet", 32'(bram_we[0]), 32'd0);
    @(negedge clk);
    check("rr2_we_after", 32'(bram_we[0]), 32'd1);
    check("rr2_waddr", 32'(bram_addr[0]), 32'h11);
    check("rr2_wdata", 32'(bram_wdata[0]), 32'h22);

    // Same address, last grant was write: write still goes first
    @(negedge clk);
    req0(1'b1, 7'h07, 8'h3C, 1'b1, 7'h07);
    @(negedge clk);
    check("raw_we", 32'(bram_we[0]), 32'd1);
    check("raw_re", 32'(bram_re[0]), 32'd0);
    check("raw_addr", 32'(bram_addr[0]), 32'h07);
    wait_rd_dv(0, d);
    check("raw_rdata", 32'(d), 32'h3C);

    // Reset while a read is waiting for BRAM data
    req0(1'b0, '0, '0, 1'b1, 7'h07);
    @(negedge clk);
    @(negedge clk);
    check("rst_in_wait", 32'(rd_ready[0]), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_values("rst_wait");
    @(negedge clk);
    check("rst_no_dv", 32'(rd_dv[0]), 32'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_dv_after", 32'(rd_dv[0]), 32'd0);
    end
    req0(1'b0, '0, '0, 1'b1, 7'h07);
    wait_rd_dv(0, d);
    check("rst_next_read", 32'(d), 32'h3C);

    // Randomized streams, one instance per read latency
    for (int k = 0; k < int'(NI); k++) begin
      pulse_reset();
      run_random(k, 1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
